// File: rtl/prbs_link_pkg.sv
// Shared types and helpers for the PRBS-31 link checker: FSM states,
// generator tap positions and a saturating 32-bit add for the status counters.
package prbs_link_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SEARCH,
        LOCKED
    } linkState_e;

    localparam int PRBS_TAP_A = 30;
    localparam int PRBS_TAP_B = 27;

    localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

    function automatic logic [31:0] satAdd32(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[32] ? CNT_MAX : sum[31:0];
    endfunction

endpackage

// File: rtl/prbs31_word_gen.sv
// Combinational PRBS-31 (x^31 + x^28 + 1) word generator: advances a 31-bit
// state DATA_W serial steps, word MSB produced first.
module prbs31_word_gen
    import prbs_link_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [30:0]       state_i,
    output logic [DATA_W-1:0] word_o,
    output logic [30:0]       next_o
);

    logic [30:0] lfsr;
    logic        fbBit;

    always_comb begin
        lfsr   = state_i;
        fbBit  = 1'b0;
        word_o = '0;
        for (int i = DATA_W - 1; i >= 0; i--) begin
            fbBit     = lfsr[PRBS_TAP_A] ^ lfsr[PRBS_TAP_B];
            lfsr      = {lfsr[29:0], fbBit};
            word_o[i] = fbBit;
        end
        next_o = lfsr;
    end

endmodule

// File: rtl/prbs_link_checker.sv
// Per-lane PRBS-31 generator and self-synchronising checker with saturating
// status counters. Define PRBS_BIT_ERR_COUNT_EN to count errored bits instead of words.
module prbs_link_checker
    import prbs_link_pkg::*;
#(
    parameter int          DATA_W      = 64,
    parameter logic [30:0] SEED        = 31'h7FFFFFFF,
    parameter int          LOCK_THRESH = 16,
    parameter int          LOSS_THRESH = 8
) (
    input  logic              wci_Clk,
    input  logic              wci_MReset_n,
    input  logic              enable,
    input  logic              clear,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic [31:0]       xaui_ok,
    output logic [31:0]       tx_count,
    output logic [31:0]       rx_count,
    output logic [31:0]       err_count
);

    // An all-zero LFSR would lock up, so a zero seed falls back to all-ones.
    localparam logic [30:0] SEED_INIT = (SEED == 31'd0) ? 31'h7FFFFFFF : SEED;
    localparam logic [7:0]  LOCK_LAST = 8'(LOCK_THRESH - 1);
    localparam logic [7:0]  LOSS_LAST = 8'(LOSS_THRESH - 1);

    logic [30:0]       genState_q;
    logic [DATA_W-1:0] txData_q;
    logic              txValid_q;
    logic [DATA_W-1:0] genWord;
    logic [30:0]       genNext;

    linkState_e        state_q, state_d;
    logic              havePrev_q, havePrev_d;
    logic [30:0]       prevRx_q, prevRx_d;
    logic [7:0]        matchCnt_q, matchCnt_d;
    logic [7:0]        missCnt_q, missCnt_d;
    logic              locked_q;
    logic [31:0]       errInc_d;

    logic [DATA_W-1:0] expWord;
    logic [30:0]       unusedPredNext;
    logic [DATA_W-1:0] diffWord;
    logic              mismatch;
    logic              rxAccept;
    logic [31:0]       errWeight;

    logic [31:0]       txCount_q, rxCount_q, errCount_q;

    prbs31_word_gen #(.DATA_W(DATA_W)) u_txGen (
        .state_i (genState_q),
        .word_o  (genWord),
        .next_o  (genNext)
    );

    prbs31_word_gen #(.DATA_W(DATA_W)) u_predGen (
        .state_i (prevRx_q),
        .word_o  (expWord),
        .next_o  (unusedPredNext)
    );

    always_ff @(posedge wci_Clk or negedge wci_MReset_n) begin
        if (!wci_MReset_n) begin
            genState_q <= SEED_INIT;
            txData_q   <= '0;
            txValid_q  <= 1'b0;
        end else begin
            if (enable) begin
                genState_q <= genNext;
                txData_q   <= genWord;
            end
            txValid_q <= enable;
        end
    end

    assign diffWord = rx_data ^ expWord;
    assign mismatch = |diffWord;
    assign rxAccept = enable && rx_valid && (state_q != IDLE);

`ifdef PRBS_BIT_ERR_COUNT_EN
    localparam int PCW = $clog2(DATA_W) + 1;
    logic [PCW-1:0] bitErrs;

    always_comb begin
        bitErrs = '0;
        for (int i = 0; i < DATA_W; i++) begin
            bitErrs = bitErrs + PCW'(diffWord[i]);
        end
    end

    assign errWeight = {{(32 - PCW){1'b0}}, bitErrs};
`else
    assign errWeight = 32'd1;
`endif

    // Every valid word becomes the seed for the next prediction, so the
    // checker re-aligns itself one word after any corruption.
    always_comb begin
        state_d    = state_q;
        havePrev_d = havePrev_q;
        prevRx_d   = prevRx_q;
        matchCnt_d = matchCnt_q;
        missCnt_d  = missCnt_q;
        errInc_d   = '0;

        if (!enable) begin
            state_d    = IDLE;
            havePrev_d = 1'b0;
            matchCnt_d = '0;
            missCnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d    = SEARCH;
                    havePrev_d = 1'b0;
                    matchCnt_d = '0;
                    missCnt_d  = '0;
                end
                SEARCH: begin
                    if (rx_valid) begin
                        prevRx_d   = rx_data[30:0];
                        havePrev_d = 1'b1;
                        if (havePrev_q) begin
                            if (mismatch) begin
                                matchCnt_d = '0;
                            end else if (matchCnt_q == LOCK_LAST) begin
                                state_d    = LOCKED;
                                matchCnt_d = '0;
                                missCnt_d  = '0;
                            end else begin
                                matchCnt_d = matchCnt_q + 8'd1;
                            end
                        end
                    end
                end
                LOCKED: begin
                    if (rx_valid) begin
                        prevRx_d   = rx_data[30:0];
                        havePrev_d = 1'b1;
                        if (havePrev_q) begin
                            if (mismatch) begin
                                errInc_d = errWeight;
                                if (missCnt_q == LOSS_LAST) begin
                                    state_d    = SEARCH;
                                    missCnt_d  = '0;
                                    matchCnt_d = '0;
                                end else begin
                                    missCnt_d = missCnt_q + 8'd1;
                                end
                            end else begin
                                missCnt_d = '0;
                            end
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge wci_Clk or negedge wci_MReset_n) begin
        if (!wci_MReset_n) begin
            state_q    <= IDLE;
            havePrev_q <= 1'b0;
            prevRx_q   <= '0;
            matchCnt_q <= '0;
            missCnt_q  <= '0;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            havePrev_q <= havePrev_d;
            prevRx_q   <= prevRx_d;
            matchCnt_q <= matchCnt_d;
            missCnt_q  <= missCnt_d;
            locked_q   <= (state_d == LOCKED);
        end
    end

    // clear wins over a same-cycle increment; FSM and LFSRs are untouched by it.
    always_ff @(posedge wci_Clk or negedge wci_MReset_n) begin
        if (!wci_MReset_n) begin
            txCount_q  <= '0;
            rxCount_q  <= '0;
            errCount_q <= '0;
        end else if (clear) begin
            txCount_q  <= '0;
            rxCount_q  <= '0;
            errCount_q <= '0;
        end else begin
            txCount_q  <= satAdd32(txCount_q, {31'd0, txValid_q});
            rxCount_q  <= satAdd32(rxCount_q, {31'd0, rxAccept});
            errCount_q <= satAdd32(errCount_q, errInc_d);
        end
    end

    assign tx_data   = txData_q;
    assign tx_valid  = txValid_q;
    assign xaui_ok   = {31'd0, locked_q};
    assign tx_count  = txCount_q;
    assign rx_count  = rxCount_q;
    assign err_count = errCount_q;

endmodule

// File: tb/tb_prbs_link_checker.sv
// Self-checking bench for prbs_link_checker: a bit-sequence model of the link
// checked every cycle, plus directed lock/error/loss/saturation/reset scenarios.
module tb_prbs_link_checker;

    localparam int          DATA_W      = 64;
    localparam int          LOCK_THRESH = 16;
    localparam int          LOSS_THRESH = 8;
    localparam logic [30:0] SEED        = 31'h7FFFFFFF;
    localparam logic [63:0] FIRST_WORD  = 64'h0000_000E_0000_00FC;
    localparam longint      SAT         = 64'h0000_0000_FFFF_FFFF;
    localparam longint      PRELOAD     = 64'h0000_0000_FFFF_FFFE;

    logic        clk = 1'b0;
    logic        rstN = 1'b1;
    logic        enable = 1'b0;
    logic        clear = 1'b0;
    logic        rxValid = 1'b0;
    logic [63:0] rxData = '0;
    logic [63:0] txData;
    logic        txValid;
    logic [31:0] xauiOk, txCount, rxCount, errCount;

    int nVec = 0;
    int nFail = 0;
    bit checkEn = 1'b0;
    int preloadSeq = 0;

    prbs_link_checker #(
        .DATA_W      (DATA_W),
        .SEED        (SEED),
        .LOCK_THRESH (LOCK_THRESH),
        .LOSS_THRESH (LOSS_THRESH)
    ) dut (
        .wci_Clk      (clk),
        .wci_MReset_n (rstN),
        .enable       (enable),
        .clear        (clear),
        .tx_data      (txData),
        .tx_valid     (txValid),
        .rx_data      (rxData),
        .rx_valid     (rxValid),
        .xaui_ok      (xauiOk),
        .tx_count     (txCount),
        .rx_count     (rxCount),
        .err_count    (errCount)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Bit-sequence form of the polynomial: x[n] = x[n-31] ^ x[n-28], oldest bit first.
    function automatic logic [63:0] prbsWord(input logic [30:0] st);
        bit          seq[$];
        logic [63:0] w;
        w = '0;
        for (int k = 30; k >= 0; k--) seq.push_back(st[k]);
        for (int n = 0; n < 64; n++) begin
            seq.push_back(seq[n] ^ seq[n + 3]);
            w[63 - n] = seq[31 + n];
        end
        return w;
    endfunction

    function automatic longint satInc(input longint c, input longint inc);
        return (c + inc > SAT) ? SAT : c + inc;
    endfunction

    logic [30:0] mTxState = SEED;
    logic [63:0] mTxData = '0;
    logic        mTxValid = 1'b0;
    bit          mActive = 1'b0;
    bit          mLocked = 1'b0;
    bit          mHavePrev = 1'b0;
    logic [30:0] mPrev = '0;
    int          mRun = 0;
    int          mMiss = 0;
    longint      mTx = 0, mRx = 0, mErr = 0;
    int          mSeq = 0;
    longint      txInc, rxInc, errInc;
    logic [63:0] expW;

    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            mTxState = SEED; mTxData = '0; mTxValid = 1'b0;
            mActive = 1'b0; mLocked = 1'b0; mHavePrev = 1'b0; mPrev = '0;
            mRun = 0; mMiss = 0; mTx = 0; mRx = 0; mErr = 0;
            mSeq = preloadSeq;
        end else begin
            if (mSeq != preloadSeq) begin
                mTx = PRELOAD; mRx = PRELOAD; mErr = PRELOAD;
                mSeq = preloadSeq;
            end
            txInc  = mTxValid ? 1 : 0;
            rxInc  = (enable && rxValid && mActive) ? 1 : 0;
            errInc = 0;
            if (!enable) begin
                mActive = 1'b0; mLocked = 1'b0; mHavePrev = 1'b0; mRun = 0; mMiss = 0;
            end else if (!mActive) begin
                mActive = 1'b1; mHavePrev = 1'b0; mRun = 0; mMiss = 0;
            end else if (rxValid) begin
                expW = prbsWord(mPrev);
                if (mHavePrev) begin
                    if (!mLocked) begin
                        if (rxData != expW) mRun = 0;
                        else begin
                            mRun++;
                            if (mRun == LOCK_THRESH) begin mLocked = 1'b1; mRun = 0; mMiss = 0; end
                        end
                    end else if (rxData != expW) begin
`ifdef PRBS_BIT_ERR_COUNT_EN
                        errInc = $countones(rxData ^ expW);
`else
                        errInc = 1;
`endif
                        mMiss++;
                        if (mMiss == LOSS_THRESH) begin mLocked = 1'b0; mMiss = 0; mRun = 0; end
                    end else begin
                        mMiss = 0;
                    end
                end
                mPrev = rxData[30:0];
                mHavePrev = 1'b1;
            end
            if (clear) begin
                mTx = 0; mRx = 0; mErr = 0;
            end else begin
                mTx = satInc(mTx, txInc); mRx = satInc(mRx, rxInc); mErr = satInc(mErr, errInc);
            end
            if (enable) begin
                mTxData  = prbsWord(mTxState);
                mTxState = mTxData[30:0];
            end
            mTxValid = enable;
        end
    end

    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("tx_valid", {63'd0, txValid}, {63'd0, mTxValid});
            checkOutput("tx_data", txData, mTxData);
            checkOutput("xaui_ok", {32'd0, xauiOk}, {63'd0, mLocked});
            if (mSeq == preloadSeq) begin
                checkOutput("tx_count", {32'd0, txCount}, mTx);
                checkOutput("rx_count", {32'd0, rxCount}, mRx);
                checkOutput("err_count", {32'd0, errCount}, mErr);
            end
        end
    end

    // mode 0: loopback with optional bit flips, 1: random garbage, other: rx idle.
    task automatic applyStimulus(input logic en, input logic clr, input int mode, input logic [63:0] flip);
        enable = en;
        clear  = clr;
        case (mode)
            0: begin rxData = txData ^ flip; rxValid = txValid; end
            1: begin rxData = {$urandom, $urandom}; rxValid = 1'b1; end
            default: begin rxData = txData; rxValid = 1'b0; end
        endcase
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_tx_data"}, txData, 64'd0);
        checkOutput({tag, "_tx_valid"}, {63'd0, txValid}, 64'd0);
        checkOutput({tag, "_xaui_ok"}, {32'd0, xauiOk}, 64'd0);
        checkOutput({tag, "_tx_count"}, {32'd0, txCount}, 64'd0);
        checkOutput({tag, "_rx_count"}, {32'd0, rxCount}, 64'd0);
        checkOutput({tag, "_err_count"}, {32'd0, errCount}, 64'd0);
    endtask

    initial begin
        logic        en, clr;
        int          mode;
        logic [63:0] flip;
        logic [63:0] triple;
        longint      errAfterTriple;

        #2 rstN = 1'b0;
        checkEn = 1'b1;
        #1 checkAllZero("reset");
        #9 rstN = 1'b1;
        @(posedge clk);
        #1;

        checkOutput("model_first_word", prbsWord(SEED), FIRST_WORD);

        // Loopback lock: 1 seed word plus LOCK_THRESH matching words.
        for (int i = 1; i <= 18; i++) begin
            applyStimulus(1'b1, 1'b0, 0, '0);
            if (i == 1) begin
                checkOutput("first_tx_word", txData, FIRST_WORD);
                checkOutput("first_tx_valid", {63'd0, txValid}, 64'd1);
            end
            if (i == 17) begin
                checkOutput("prelock_xaui_ok", {32'd0, xauiOk}, 64'd0);
                checkOutput("prelock_rx_count", {32'd0, rxCount}, 64'd16);
                checkOutput("prelock_tx_count", {32'd0, txCount}, 64'd16);
            end
            if (i == 18) begin
                checkOutput("lock_xaui_ok", {32'd0, xauiOk}, 64'd1);
                checkOutput("lock_rx_count", {32'd0, rxCount}, 64'd17);
                checkOutput("lock_tx_count", {32'd0, txCount}, 64'd17);
                checkOutput("lock_err_count", {32'd0, errCount}, 64'd0);
            end
        end

        applyStimulus(1'b1, 1'b0, 0, 64'd1 << 40);
        checkOutput("bit40_err_count", {32'd0, errCount}, 64'd1);
        checkOutput("bit40_xaui_ok", {32'd0, xauiOk}, 64'd1);
        repeat (3) applyStimulus(1'b1, 1'b0, 0, '0);

        triple = (64'd1 << 40) | (64'd1 << 41) | (64'd1 << 63);
`ifdef PRBS_BIT_ERR_COUNT_EN
        errAfterTriple = 4;
`else
        errAfterTriple = 2;
`endif
        applyStimulus(1'b1, 1'b0, 0, triple);
        repeat (3) applyStimulus(1'b1, 1'b0, 0, '0);
        checkOutput("triple_err_count", {32'd0, errCount}, errAfterTriple);

`ifndef PRBS_BIT_ERR_COUNT_EN
        applyStimulus(1'b1, 1'b0, 0, 64'd1 << 5);
        repeat (3) applyStimulus(1'b1, 1'b0, 0, '0);
        checkOutput("bit5_err_count", {32'd0, errCount}, 64'd4);
        checkOutput("bit5_xaui_ok", {32'd0, xauiOk}, 64'd1);
`endif

        for (int i = 1; i <= LOSS_THRESH; i++) begin
            applyStimulus(1'b1, 1'b0, 1, '0);
            if (i == LOSS_THRESH - 1) checkOutput("preloss_xaui_ok", {32'd0, xauiOk}, 64'd1);
            if (i == LOSS_THRESH) checkOutput("loss_xaui_ok", {32'd0, xauiOk}, 64'd0);
        end
        for (int i = 1; i <= 17; i++) begin
            applyStimulus(1'b1, 1'b0, 0, '0);
            if (i == 16) checkOutput("prerelock_xaui_ok", {32'd0, xauiOk}, 64'd0);
            if (i == 17) checkOutput("relock_xaui_ok", {32'd0, xauiOk}, 64'd1);
        end

        force dut.txCount_q  = 32'hFFFF_FFFE;
        force dut.rxCount_q  = 32'hFFFF_FFFE;
        force dut.errCount_q = 32'hFFFF_FFFE;
        preloadSeq++;
        #1;
        release dut.txCount_q;
        release dut.rxCount_q;
        release dut.errCount_q;
        repeat (3) applyStimulus(1'b1, 1'b0, 0, 64'd1 << 40);
        checkOutput("sat_tx_count", {32'd0, txCount}, SAT);
        checkOutput("sat_rx_count", {32'd0, rxCount}, SAT);
        checkOutput("sat_err_count", {32'd0, errCount}, SAT);
        applyStimulus(1'b1, 1'b1, 0, '0);
        checkOutput("clear_tx_count", {32'd0, txCount}, 64'd0);
        checkOutput("clear_rx_count", {32'd0, rxCount}, 64'd0);
        checkOutput("clear_err_count", {32'd0, errCount}, 64'd0);
        checkOutput("clear_xaui_ok", {32'd0, xauiOk}, 64'd1);

        repeat (4) applyStimulus(1'b1, 1'b0, 0, '0);
        #3 rstN = 1'b0;
        #1 checkAllZero("async_reset");
        #2 rstN = 1'b1;
        rxValid = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("post_reset_tx_word", txData, FIRST_WORD);
        checkOutput("post_reset_xaui_ok", {32'd0, xauiOk}, 64'd0);

        for (int c = 0; c < 1500; c++) begin
            en   = ($urandom_range(0, 99) >= 2);
            clr  = ($urandom_range(0, 99) < 2);
            mode = ($urandom_range(0, 99) < 5) ? 2 : (($urandom_range(0, 99) < 2) ? 1 : 0);
            flip = ($urandom_range(0, 99) < 3) ? (64'd1 << $urandom_range(0, 63)) : 64'd0;
            applyStimulus(en, clr, mode, flip);
        end

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
